seq_divider: RTL

//   Multi-cycle restoring integer divider for the execute stage; the inverse of the multiply path.

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_step.sv | 27 ++
 rtl/seq_divider.sv | 110 +++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and default width.
package seq_divider_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-divide step: shift {rem,q} left by one, then trial subtract.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// The caller guarantees rem_in < dvsr, so a successful trial result always fits in WIDTH bits.
module seq_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dvsr,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;
  logic             trial_unused;

  assign shifted      = {rem_in, q_in[WIDTH-1]};
  assign trial        = {1'b0, shifted} - {2'b00, dvsr};
  assign trial_neg    = trial[WIDTH+1];
  assign trial_unused = trial[WIDTH];

  assign rem_out = trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_out   = {q_in[WIDTH-2:0], ~trial_neg};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with start/busy/done handshake and flush.
// Latency: done visible after WIDTH+1 edges following the accepting edge; 0 extra for divide-by-zero.
// Backpressure: start is ignored while busy; no queuing, flush cancels without a done pulse.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, q_r, dvsr_r;
  logic             q_neg_r, r_neg_r;
  logic [WIDTH-1:0] step_rem, step_q;

  logic             dvnd_neg, dvsr_neg, div0, can_start, accept, last_step;
  logic [WIDTH-1:0] dvnd_mag, dvsr_mag;

  assign dvnd_neg  = is_signed & dividend[WIDTH-1];
  assign dvsr_neg  = is_signed & divisor[WIDTH-1];
  assign dvnd_mag  = dvnd_neg ? -dividend : dividend;
  assign dvsr_mag  = dvsr_neg ? -divisor : divisor;
  assign div0      = (divisor == '0);
  assign can_start = (state == S_IDLE) || (state == S_DONE);
  assign accept    = can_start & start & ~flush;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  seq_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .dvsr    (dvsr_r),
    .q_in    (q_r),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = div0 ? S_DONE : S_RUN;
        S_RUN:   if (last_step) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  state_nxt = start ? (div0 ? S_DONE : S_RUN) : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      dvsr_r    <= '0;
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      div_zero <= div0;
      if (div0) begin
        quotient  <= '1;
        remainder <= dividend;
      end else begin
        rem_r   <= '0;
        q_r     <= dvnd_mag;
        dvsr_r  <= dvsr_mag;
        q_neg_r <= dvnd_neg ^ dvsr_neg;
        r_neg_r <= dvnd_neg;
        cnt     <= '0;
      end
    end else if (!flush && state == S_RUN) begin
      rem_r <= step_rem;
      q_r   <= step_q;
      cnt   <= cnt + 1'b1;
    end else if (!flush && state == S_FIX) begin
      // MIN / -1 lands here as quotient MIN with no sign flip, which is the wanted result.
      quotient  <= q_neg_r ? -q_r : q_r;
      remainder <= r_neg_r ? -rem_r : rem_r;
      div_zero  <= 1'b0;
    end
  end

endmodule
